axi_b_resp_allocator: RTL and testbench

- Next-generation write-response (B channel) allocator for one AXI target port of the node.
- Merges the B channels from N_INIT_PORT slave-side ports using a built-in round-robin arbiter that holds its grant until the handshake completes.
- Strips the routing ID bits and counts outstanding write transactions with a parametrised saturating counter.
- Queues up to ERR_DEPTH decode-error responses in a FIFO, replacing the single sampled error slot of the previous generation.

---
 rtl/axi_node_pkg.sv | 23 ++
 rtl/axi_b_err_fifo.sv | 52 +++++
 rtl/axi_b_resp_allocator.sv | 188 ++++++++++++++++++
 tb/tb_axi_b_resp_allocator.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_node_pkg.sv
// Shared types for the AXI node write-response path.
// Response codes, B allocator states and the error FIFO entry.
package axi_node_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      HOLD  = 2'd1,
      ERROR = 2'd2
   } b_state_e;

   localparam int ERR_ID_W   = 16;
   localparam int ERR_USER_W = 6;

   typedef struct packed {
      logic [ERR_ID_W-1:0]   id;
      logic [ERR_USER_W-1:0] user;
   } err_entry_t;

endpackage

// File: rtl/axi_b_err_fifo.sv
// Small synchronous FIFO holding pending decode-error responses.
// Pointers carry one extra wrap bit so full and empty are distinct.
module axi_b_err_fifo
   import axi_node_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = ERR_ID_W + ERR_USER_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [W-1:0]  mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // a pop in the same cycle frees the slot the push will use
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   // advance read/write pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // storage needs no reset; only entries behind wr_ptr are read
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/axi_b_resp_allocator.sv
// B-channel allocator: round-robin merge of slave B channels,
// outstanding-write counter and queued decode-error responses.
module axi_b_resp_allocator
   import axi_node_pkg::*;
#(
   parameter int         AXI_USER_W  = 6,
   parameter int         N_INIT_PORT = 4,
   parameter int         AXI_ID_IN   = 16,
   parameter int         N_TARG_PORT = 7,
   parameter int         AXI_ID_OUT  = AXI_ID_IN + $clog2(N_TARG_PORT),
   parameter int         CNT_W       = 10,
   parameter int         ERR_DEPTH   = 4,
   parameter logic [1:0] ERR_RESP    = RESP_DECERR
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [N_INIT_PORT-1:0][AXI_ID_OUT-1:0] bid_i,
   input  logic [N_INIT_PORT-1:0][1:0]            bresp_i,
   input  logic [N_INIT_PORT-1:0][AXI_USER_W-1:0] buser_i,
   input  logic [N_INIT_PORT-1:0]                 bvalid_i,
   output logic [N_INIT_PORT-1:0]                 bready_o,
   output logic [AXI_ID_IN-1:0]                   bid_o,
   output logic [1:0]                             bresp_o,
   output logic [AXI_USER_W-1:0]                  buser_o,
   output logic                                   bvalid_o,
   input  logic                                   bready_i,
   input  logic                                   incr_req_i,
   output logic                                   full_counter_o,
   output logic                                   outstanding_trans_o,
   input  logic                                   error_req_i,
   input  logic [AXI_ID_IN-1:0]                   error_id_i,
   input  logic [AXI_USER_W-1:0]                  error_user_i,
   output logic                                   error_gnt_o,
   output logic                                   err_fifo_full_o
);

   localparam int IW = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;
   localparam int EW = AXI_ID_IN + AXI_USER_W;
   localparam int RW = AXI_ID_OUT - AXI_ID_IN;

   b_state_e      state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] gnt_q;
   logic [CNT_W-1:0] cnt;

   logic          arb_hit;
   logic [IW-1:0] arb_idx;
   logic [IW-1:0] scan_idx;
   logic          sel_hit;
   logic [IW-1:0] sel_idx;
   logic          err_beat;
   logic          decr;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [EW-1:0] fifo_head;
   logic          route_bits_unused;

   function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
      return IW'((int'(g) + 1) % N_INIT_PORT);
   endfunction

   // routing bits are stripped; fold them away explicitly
   always_comb begin
      route_bits_unused = 1'b0;
      for (int p = 0; p < N_INIT_PORT; p++) begin
         if (RW > 0) route_bits_unused ^= ^bid_i[p][AXI_ID_OUT-1:AXI_ID_IN];
      end
   end

   // first requester at or after the round-robin pointer
   always_comb begin
      arb_hit  = 1'b0;
      arb_idx  = '0;
      scan_idx = '0;
      for (int k = 0; k < N_INIT_PORT; k++) begin
         scan_idx = IW'((int'(rr_ptr) + k) % N_INIT_PORT);
         if (!arb_hit && bvalid_i[scan_idx]) begin
            arb_hit = 1'b1;
            arb_idx = scan_idx;
         end
      end
   end

   // pick which real port (if any) owns the output this cycle
   always_comb begin
      sel_hit = 1'b0;
      sel_idx = arb_idx;
      case (state)
         ARB:  sel_hit = arb_hit;
         HOLD: begin
            sel_hit = 1'b1;
            sel_idx = gnt_q;
         end
         default: sel_hit = 1'b0;
      endcase
      if (rst) sel_hit = 1'b0;
   end

   assign err_beat = (state == ERROR) & ~rst;

   // merged B channel: real payload, error beat, or idle zeros
   always_comb begin
      bvalid_o = sel_hit | err_beat;
      bready_o = '0;
      bid_o    = '0;
      bresp_o  = '0;
      buser_o  = '0;
      if (sel_hit) begin
         bready_o[sel_idx] = bready_i;
         bid_o   = bid_i[sel_idx][AXI_ID_IN-1:0];
         bresp_o = bresp_i[sel_idx];
         buser_o = buser_i[sel_idx];
      end else if (err_beat) begin
         bid_o   = fifo_head[EW-1:AXI_USER_W];
         bresp_o = ERR_RESP;
         buser_o = fifo_head[AXI_USER_W-1:0];
      end
   end

   assign decr        = bvalid_o & bready_i & (state != ERROR);
   assign pop         = err_beat & bready_i;
   assign error_gnt_o = error_req_i & (~fifo_full | pop);

   assign full_counter_o      = &cnt;
   assign outstanding_trans_o = |cnt;
   assign err_fifo_full_o     = fifo_full;

   // arbitration FSM: grant, hold until handshake, or emit an error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ARB;
         rr_ptr <= '0;
         gnt_q  <= '0;
      end else begin
         case (state)
            ARB: begin
               if (arb_hit) begin
                  if (bready_i) begin
                     rr_ptr <= rr_next(arb_idx);
                  end else begin
                     gnt_q <= arb_idx;
                     state <= HOLD;
                  end
               end else if (!fifo_empty && cnt == '0) begin
                  state <= ERROR;
               end
            end
            HOLD: begin
               if (bready_i) begin
                  rr_ptr <= rr_next(gnt_q);
                  state  <= ARB;
               end
            end
            ERROR: begin
               if (bready_i) state <= ARB;
            end
            default: state <= ARB;
         endcase
      end
   end

   // saturating outstanding-write counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (incr_req_i && !decr) begin
         if (!(&cnt)) cnt <= cnt + 1'b1;
      end else if (decr && !incr_req_i) begin
         if (cnt != '0) cnt <= cnt - 1'b1;
      end
   end

   axi_b_err_fifo #(
      .DEPTH (ERR_DEPTH),
      .W     (EW)
   ) u_err_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (error_gnt_o),
      .pop   (pop),
      .din   ({error_id_i, error_user_i}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

endmodule

// File: tb/tb_axi_b_resp_allocator.sv
// Bench for the B-channel allocator: constant vector table,
// directed corner sequences and random traffic against a model.
module tb_axi_b_resp_allocator;

   localparam int N   = 4;
   localparam int IDI = 16;
   localparam int IDO = 19;
   localparam int UW  = 6;
   localparam int DEP = 4;
   localparam int CMAX = 1023;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0][IDO-1:0] bid_i;
   logic [N-1:0][1:0]     bresp_i;
   logic [N-1:0][UW-1:0]  buser_i;
   logic [N-1:0]          bvalid_i;
   logic [N-1:0]          bready_o;
   logic [IDI-1:0]        bid_o;
   logic [1:0]            bresp_o;
   logic [UW-1:0]         buser_o;
   logic                  bvalid_o;
   logic                  bready_i;
   logic                  incr_req_i;
   logic                  full_counter_o;
   logic                  outstanding_trans_o;
   logic                  error_req_i;
   logic [IDI-1:0]        error_id_i;
   logic [UW-1:0]         error_user_i;
   logic                  error_gnt_o;
   logic                  err_fifo_full_o;

   always #5 clk = ~clk;

   axi_b_resp_allocator dut (
      .clk                 (clk),
      .rst                 (rst),
      .bid_i               (bid_i),
      .bresp_i             (bresp_i),
      .buser_i             (buser_i),
      .bvalid_i            (bvalid_i),
      .bready_o            (bready_o),
      .bid_o               (bid_o),
      .bresp_o             (bresp_o),
      .buser_o             (buser_o),
      .bvalid_o            (bvalid_o),
      .bready_i            (bready_i),
      .incr_req_i          (incr_req_i),
      .full_counter_o      (full_counter_o),
      .outstanding_trans_o (outstanding_trans_o),
      .error_req_i         (error_req_i),
      .error_id_i          (error_id_i),
      .error_user_i        (error_user_i),
      .error_gnt_o         (error_gnt_o),
      .err_fifo_full_o     (err_fifo_full_o)
   );

   typedef struct packed {
      logic           bv;
      logic [N-1:0]   br;
      logic [IDI-1:0] id;
      logic [1:0]     rs;
      logic [UW-1:0]  us;
      logic           fc;
      logic           ot;
      logic           eg;
      logic           ef;
   } obs_t;

   typedef struct {
      logic [N-1:0]   bv;
      logic           rdy;
      logic [N-1:0]   exp_br;
      logic           exp_bv;
      logic [IDI-1:0] exp_id;
   } vec_t;

   // reference model state: plain ints and a queue
   int   m_ptr;
   int   m_hold;
   bit   m_err;
   int   m_cnt;
   logic [IDI+UW-1:0] m_q [$];

   int   total = 0;
   int   bad   = 0;
   obs_t last_a;
   obs_t last_e;

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic obs_t sample();
      obs_t a;
      a.bv = bvalid_o;
      a.br = bready_o;
      a.id = bid_o;
      a.rs = bresp_o;
      a.us = buser_o;
      a.fc = full_counter_o;
      a.ot = outstanding_trans_o;
      a.eg = error_gnt_o;
      a.ef = err_fifo_full_o;
      return a;
   endfunction

   function automatic int model_grant();
      int p;
      if (rst || m_err) return -1;
      if (m_hold >= 0) return m_hold;
      for (int k = 0; k < N; k++) begin
         p = (m_ptr + k) % N;
         if (bvalid_i[p]) return p;
      end
      return -1;
   endfunction

   function automatic obs_t model_out();
      obs_t o;
      int   g;
      o = '0;
      if (rst) begin
         o.eg = error_req_i;
         return o;
      end
      g = model_grant();
      if (m_err) begin
         o.bv = 1'b1;
         o.rs = 2'b11;
         o.id = m_q[0][IDI+UW-1:UW];
         o.us = m_q[0][UW-1:0];
      end else if (g >= 0) begin
         o.bv    = 1'b1;
         o.br[g] = bready_i;
         o.id    = bid_i[g][IDI-1:0];
         o.rs    = bresp_i[g];
         o.us    = buser_i[g];
      end
      o.fc = (m_cnt == CMAX);
      o.ot = (m_cnt != 0);
      o.eg = error_req_i && (m_q.size() < DEP || (m_err && bready_i));
      o.ef = (m_q.size() == DEP);
      return o;
   endfunction

   task automatic model_reset();
      m_ptr  = 0;
      m_hold = -1;
      m_err  = 1'b0;
      m_cnt  = 0;
      m_q.delete();
   endtask

   // one clock: compare against model, then advance the model
   task automatic cycle();
      obs_t e;
      int   g;
      int   nc;
      bit   decr;
      bit   hs;
      bit   push;
      bit   pop;
      bit   go_err;
      logic [IDI+UW-1:0] din;
      #2;
      e = model_out();
      last_e = e;
      last_a = sample();
      chk("model", 64'(last_a), 64'(e));
      g    = model_grant();
      hs   = bready_i;
      decr = e.bv && hs && !m_err;
      nc   = m_cnt;
      if (incr_req_i && !decr && nc < CMAX) nc++;
      else if (decr && !incr_req_i && nc > 0) nc--;
      push   = e.eg;
      pop    = m_err && hs;
      go_err = !m_err && g < 0 && m_q.size() > 0 && m_cnt == 0;
      din    = {error_id_i, error_user_i};
      @(posedge clk);
      m_cnt = nc;
      if (m_err) begin
         if (hs) m_err = 1'b0;
      end else if (g >= 0) begin
         if (hs) begin
            m_ptr  = (g + 1) % N;
            m_hold = -1;
         end else begin
            m_hold = g;
         end
      end else if (go_err) begin
         m_err = 1'b1;
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(din);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      bvalid_i    = '0;
      bready_i    = 1'b0;
      incr_req_i  = 1'b0;
      error_req_i = 1'b0;
      model_reset();
      #1;
      chk("reset_state", 64'(sample()), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   vec_t tbl [7];
   logic [IDI-1:0] emitted [$];

   initial begin
      bid_i[0]   = 19'h1A0B0;
      bid_i[1]   = 19'h2C0D1;
      bid_i[2]   = 19'h70005;
      bid_i[3]   = 19'h5F00E;
      bresp_i    = {2'b10, 2'b00, 2'b01, 2'b00};
      buser_i    = {6'h2A, 6'h15, 6'h3C, 6'h07};
      error_id_i   = '0;
      error_user_i = '0;

      tbl[0] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 16'h0005};
      tbl[1] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 16'hF00E};
      tbl[2] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 16'hA0B0};
      tbl[3] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 16'hC0D1};
      tbl[4] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 16'hA0B0};
      tbl[5] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000};
      tbl[6] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 16'hC0D1};

      do_reset();

      // round-robin vectors from pointer 0
      for (int i = 0; i < 7; i++) begin
         bvalid_i = tbl[i].bv;
         bready_i = tbl[i].rdy;
         cycle();
         chk($sformatf("tbl%0d", i),
             64'({last_a.bv, last_a.br, last_a.id}),
             64'({tbl[i].exp_bv, tbl[i].exp_br, tbl[i].exp_id}));
      end

      // move pointer to 1, then hold grant on port 3
      bvalid_i = 4'b0001;
      bready_i = 1'b1;
      cycle();
      bvalid_i = 4'b1001;
      bready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("hold_id", 64'({last_a.bv, last_a.id}), 64'({1'b1, 16'hF00E}));
      end
      bready_i = 1'b1;
      cycle();
      chk("hold_release", 64'(last_a.br), 64'(4'b1000));
      bvalid_i = 4'b0001;
      cycle();
      chk("after_hold", 64'(last_a.br), 64'(4'b0001));

      // counter up/down with a coincident incr/decr
      bvalid_i   = '0;
      incr_req_i = 1'b1;
      repeat (3) cycle();
      incr_req_i = 1'b0;
      chk("cnt_up", 64'(outstanding_trans_o), 64'(1));
      bvalid_i = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         incr_req_i = (i == 1);
         cycle();
         if (i == 2) chk("cnt_one", 64'(outstanding_trans_o), 64'(1));
      end
      incr_req_i = 1'b0;
      bvalid_i   = '0;
      chk("cnt_zero", 64'(outstanding_trans_o), 64'(0));

      // saturation
      do_reset();
      incr_req_i = 1'b1;
      repeat (CMAX - 1) cycle();
      chk("sat_below", 64'(full_counter_o), 64'(0));
      cycle();
      chk("sat_full", 64'(full_counter_o), 64'(1));
      cycle();
      chk("sat_hold", 64'({full_counter_o, outstanding_trans_o}), 64'(2'b11));
      incr_req_i = 1'b0;

      // error FIFO fill, overflow refusal, ordered drain
      do_reset();
      for (int i = 0; i < 5; i++) begin
         error_req_i  = 1'b1;
         error_id_i   = 16'h1110 + 16'(i);
         error_user_i = 6'(i + 1);
         cycle();
         chk($sformatf("err_gnt%0d", i), 64'({last_a.eg, last_a.ef}),
             (i < 4) ? 64'(2'b10) : 64'(2'b01));
      end
      error_req_i = 1'b0;
      bready_i    = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (last_a.bv) begin
            chk("err_resp", 64'(last_a.rs), 64'(2'b11));
            emitted.push_back(last_a.id);
         end
      end
      chk("err_count", 64'(emitted.size()), 64'(4));
      for (int i = 0; i < 4 && i < emitted.size(); i++)
         chk("err_order", 64'(emitted[i]), 64'(16'h1110 + 16'(i)));
      chk("err_no_decr", 64'(outstanding_trans_o), 64'(0));

      // real response first, then error beat, then reset mid-beat
      do_reset();
      incr_req_i = 1'b1;
      cycle();
      incr_req_i   = 1'b0;
      error_req_i  = 1'b1;
      error_id_i   = 16'hBEEF;
      error_user_i = 6'h11;
      cycle();
      error_req_i = 1'b0;
      bvalid_i    = 4'b0010;
      bready_i    = 1'b1;
      cycle();
      chk("real_first", 64'({last_a.bv, last_a.br, last_a.rs}),
          64'({1'b1, 4'b0010, 2'b01}));
      bvalid_i = '0;
      bready_i = 1'b0;
      cycle();
      chk("err_gap", 64'(last_a.bv), 64'(0));
      #1;
      chk("err_beat", 64'({bvalid_o, bresp_o, bid_o}),
          64'({1'b1, 2'b11, 16'hBEEF}));
      rst = 1'b1;
      #1;
      chk("rst_drop", 64'(bvalid_o), 64'(0));
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) cycle();
      chk("fifo_cleared", 64'({bvalid_o, err_fifo_full_o}), 64'(0));

      // randomized traffic with AXI-legal valids
      do_reset();
      for (int c = 0; c < 800; c++) begin
         for (int p = 0; p < N; p++) begin
            if (!bvalid_i[p] && $urandom_range(0, 2) == 0) begin
               bvalid_i[p] = 1'b1;
               bid_i[p]    = 19'($urandom);
               bresp_i[p]  = 2'($urandom);
               buser_i[p]  = 6'($urandom);
            end
         end
         bready_i     = 1'($urandom);
         incr_req_i   = ($urandom_range(0, 3) == 0);
         error_req_i  = ($urandom_range(0, 5) == 0);
         error_id_i   = 16'($urandom);
         error_user_i = 6'($urandom);
         cycle();
         bvalid_i = bvalid_i & ~last_e.br;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
